regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the next core generation. Configurable data width, depth and number of read ports. Two prioritised write ports with same-cycle write-to-read bypass, and a per-register pending-write scoreboard. Sits between decode (reads, issue marking) and writeback (two retire lanes), replacing the fixed 2-read/1-write file.

Parameters:
DW, 32, data width in bits
NREG, 32, number of registers, power of two; register 0 is hard-wired to zero
AW, $clog2(NREG), register address width (derived, not overridden)
NRD, 2, number of read ports, 1..4

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
re  in  NRD  per-port read enable
raddr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
rdata  out  NRD*DW  read data, port i at bits [i*DW +: DW]
rbusy  out  NRD  port i's register has an outstanding write not yet supplied
we0  in  1  write port 0 enable (older lane)
waddr0  in  AW  write port 0 address
wdata0  in  DW  write port 0 data
we1  in  1  write port 1 enable (younger lane, higher priority)
waddr1  in  AW  write port 1 address
wdata1  in  DW  write port 1 data
iss_valid  in  1  mark a destination register as pending
iss_addr  in  AW  destination register being issued

Behaviour:
- Reset: clk and rst are the only timing/reset inputs. On a clk edge with rst=1, all NREG registers clear to 0 and all busy bits clear. Writes and issues in that cycle are ignored.
- While rst=1, rdata=0 and rbusy=0 on all ports (combinational). Deasserting rst mid-operation loses all pending state; no partial writes.
- Write: on a clk edge with rst=0, port k writes when wek=1 and waddrk!=0. If both ports target the same nonzero address, port 1's data is stored.
- Write latency: 1 cycle to the array. Bypass makes the data visible to reads combinationally in the same cycle.
- Read port i (combinational, independent per port), in priority order:
  1. rst=1 -> 0.
  2. re[i]=0 -> 0.
  3. raddr_i=0 -> 0.
  4. we1=1 and waddr1=raddr_i -> wdata1.
  5. we0=1 and waddr0=raddr_i -> wdata0.
  6. Otherwise -> array contents.
- Scoreboard: one busy bit per register; bit 0 is constant 0.
  - Set on an edge with iss_valid=1 and iss_addr!=0.
  - Cleared on an edge when either write port writes that address.
  - If set and clear hit the same register on the same edge, set wins: the new producer is still outstanding.
- rbusy[i] = re[i] & (raddr_i!=0) & busy[raddr_i] & ~(bypass hit on port i).
- Writes to a non-busy register are legal: the write happens and busy stays 0.
- Width rules: no arithmetic. Addresses are compared at full AW. Out-of-range addresses are impossible because NREG=2^AW.

Decomposition:
- Shared package/defines holds:
  - Reset and enable polarity constants (RstEnable=1, WriteEnable=1, ReadEnable=1).
  - ZeroWord and ZeroRegAddr.
  - Default DW/NREG values.
- One natural sub-module: regfile_rdport, the per-port bypass/mux/busy logic, instantiated NRD times in a generate loop. The storage array and scoreboard stay in the parent.

Test Plan:
- Reset clears state: write r5=0xDEADBEEF, then pulse rst for one edge -> read r5 returns 0x00000000 and rbusy=0. While rst=1, rdata=0 even with a bypass hit.
- Dual-write priority: same edge we0 r7=0x11111111 and we1 r7=0x22222222 -> same-cycle bypass reads 0x22222222; the next cycle's array read also returns 0x22222222.
- Bypass on all ports (NRD=4): we0 r3=0xA5A5A5A5, we1 r9=0x5A5A5A5A, read ports at r3/r9/r3/r0 in the same cycle -> 0xA5A5A5A5 / 0x5A5A5A5A / 0xA5A5A5A5 / 0x00000000.
- Zero register: we1 r0=0xFFFFFFFF and iss r0 -> read r0 returns 0 and rbusy=0 in that cycle and every later cycle.
- Scoreboard sequence:
  - iss r12 -> next cycle read r12 gives rbusy=1.
  - In the cycle we0 writes r12=0x0000CAFE: rbusy=0 and rdata=0x0000CAFE.
  - After that edge: busy is clear.
- Set beats clear: same edge iss r4 and we1 r4=0x12345678 -> next cycle read r4 returns 0x12345678 with rbusy=1; busy clears only after a later write to r4.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: enable polarities,
// zero values and default geometry.
package regfile_mp_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam int DefaultDW   = 32;
    localparam int DefaultNREG = 32;
    localparam int DefaultNRD  = 2;

    localparam logic [DefaultDW-1:0] ZeroWord    = '0;
    localparam int unsigned          ZeroRegAddr = 0;

endpackage

// File: rtl/regfile_mp_rdport.sv
// One read port: write-to-read bypass, array fallback and busy reporting.
// A bypass hit means the pending value is being supplied now, so busy is masked.
module regfile_rdport
    import regfile_mp_pkg::*;
#(
    parameter int DW = DefaultDW,
    parameter int AW = 5
) (
    input  logic          rst_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          we0_i,
    input  logic [AW-1:0] waddr0_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] waddr1_i,
    input  logic [DW-1:0] wdata1_i,
    input  logic [DW-1:0] arr_data_i,
    input  logic          busy_i,
    output logic [DW-1:0] rdata_o,
    output logic          rbusy_o
);

    logic rd_live;
    logic hit0;
    logic hit1;

    assign rd_live = (rst_i != RstEnable) && (re_i == ReadEnable)
                     && (raddr_i != AW'(ZeroRegAddr));
    assign hit1    = (we1_i == WriteEnable) && (waddr1_i == raddr_i);
    assign hit0    = (we0_i == WriteEnable) && (waddr0_i == raddr_i);

    // Younger lane (port 1) takes priority on a shared address.
    always_comb begin
        rdata_o = DW'(ZeroWord);
        if (rd_live) begin
            if (hit1) begin
                rdata_o = wdata1_i;
            end else if (hit0) begin
                rdata_o = wdata0_i;
            end else begin
                rdata_o = arr_data_i;
            end
        end
    end

    assign rbusy_o = rd_live & busy_i & ~(hit0 | hit1);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage array and pending-write scoreboard,
// with NRD independent combinational read ports.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int DW   = DefaultDW,
    parameter  int NREG = DefaultNREG,
    parameter  int NRD  = DefaultNRD,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD-1:0]    re,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  logic [DW-1:0]     wdata0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  logic [DW-1:0]     wdata1,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr
);

    logic [DW-1:0]   mem_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wr0;
    logic            wr1;
    logic            iss;

    assign wr0 = (we0 == WriteEnable) && (waddr0 != AW'(ZeroRegAddr));
    assign wr1 = (we1 == WriteEnable) && (waddr1 != AW'(ZeroRegAddr));
    assign iss = iss_valid && (iss_addr != AW'(ZeroRegAddr));

    // Set is applied after the clears so a fresh producer stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (wr0) busy_d[waddr0] = 1'b0;
        if (wr1) busy_d[waddr1] = 1'b0;
        if (iss) busy_d[iss_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= DW'(ZeroWord);
            end
            busy_q <= '0;
        end else begin
            if (wr0) mem_q[waddr0] <= wdata0;
            if (wr1) mem_q[waddr1] <= wdata1;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[p*AW +: AW];

        regfile_rdport #(
            .DW (DW),
            .AW (AW)
        ) u_rdport (
            .rst_i      (rst),
            .re_i       (re[p]),
            .raddr_i    (ra),
            .we0_i      (we0),
            .waddr0_i   (waddr0),
            .wdata0_i   (wdata0),
            .we1_i      (we1),
            .waddr1_i   (waddr1),
            .wdata1_i   (wdata1),
            .arr_data_i (mem_q[ra]),
            .busy_i     (busy_q[ra]),
            .rdata_o    (rdata[p*DW +: DW]),
            .rbusy_o    (rbusy[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (4 read ports): directed vector table, a held-busy
// sequence, then random traffic against an array-based reference model.
module tb_regfile_mp;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int AW   = 5;

    logic              clk;
    logic              rst;
    logic [NRD-1:0]    re;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rbusy;
    logic              we0;
    logic [AW-1:0]     waddr0;
    logic [DW-1:0]     wdata0;
    logic              we1;
    logic [AW-1:0]     waddr1;
    logic [DW-1:0]     wdata1;
    logic              iss_valid;
    logic [AW-1:0]     iss_addr;
    logic [3:0][4:0]   ra_v;

    assign raddr = ra_v;

    regfile_mp #(.DW(DW), .NREG(NREG), .NRD(NRD)) dut (
        .clk       (clk),
        .rst       (rst),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             rst;
        logic             we0;
        logic [4:0]       wa0;
        logic [31:0]      wd0;
        logic             we1;
        logic [4:0]       wa1;
        logic [31:0]      wd1;
        logic             iss;
        logic [4:0]       ia;
        logic [3:0]       re;
        logic [3:0][4:0]  ra;
        logic [3:0][31:0] er;
        logic [3:0]       eb;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem  [NREG];
    logic        m_busy [NREG];

    function automatic vec_t row(input int rst_, input int we0_, input int wa0_, input logic [31:0] wd0_,
                                 input int we1_, input int wa1_, input logic [31:0] wd1_,
                                 input int iss_, input int ia_, input int re_,
                                 input logic [19:0] ra_, input logic [127:0] er_, input int eb_);
        vec_t v;
        v.rst = 1'(rst_);  v.we0 = 1'(we0_); v.wa0 = 5'(wa0_); v.wd0 = wd0_;
        v.we1 = 1'(we1_);  v.wa1 = 5'(wa1_); v.wd1 = wd1_;
        v.iss = 1'(iss_);  v.ia  = 5'(ia_);  v.re  = 4'(re_);
        v.ra  = ra_;       v.er  = er_;      v.eb  = 4'(eb_);
        return v;
    endfunction

    // Only read port 0 enabled.
    function automatic vec_t row1(input int rst_, input int we0_, input int wa0_, input logic [31:0] wd0_,
                                  input int we1_, input int wa1_, input logic [31:0] wd1_,
                                  input int iss_, input int ia_, input int ra0, input logic [31:0] er0,
                                  input int eb0);
        return row(rst_, we0_, wa0_, wd0_, we1_, wa1_, wd1_, iss_, ia_, 1,
                   {15'd0, 5'(ra0)}, {96'h0, er0}, eb0);
    endfunction

    function automatic logic [31:0] m_rd(input int p);
        logic [4:0] a;
        a = ra_v[p];
        if (rst || !re[p] || a == 5'd0) return 32'h0;
        if (we1 && waddr1 == a) return wdata1;
        if (we0 && waddr0 == a) return wdata0;
        return m_mem[a];
    endfunction

    function automatic logic m_rb(input int p);
        logic [4:0] a;
        a = ra_v[p];
        if (rst || !re[p] || a == 5'd0) return 1'b0;
        if ((we1 && waddr1 == a) || (we0 && waddr0 == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic m_edge();
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_mem[r]  = 32'h0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (we0 && waddr0 != 5'd0) begin m_mem[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
            if (we1 && waddr1 != 5'd0) begin m_mem[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
            if (iss_valid && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, compare mid-cycle, then advance model with the edge.
    task automatic step(input vec_t v, input bit tbl, input string tag);
        logic [31:0] exp_d;
        logic        exp_b;
        rst = v.rst; we0 = v.we0; waddr0 = v.wa0; wdata0 = v.wd0;
        we1 = v.we1; waddr1 = v.wa1; wdata1 = v.wd1;
        iss_valid = v.iss; iss_addr = v.ia; re = v.re; ra_v = v.ra;
        @(negedge clk);
        for (int p = 0; p < NRD; p++) begin
            exp_d = tbl ? v.er[p] : m_rd(p);
            exp_b = tbl ? v.eb[p] : m_rb(p);
            check($sformatf("%s rdata%0d", tag, p), rdata[p*DW +: DW], exp_d);
            check($sformatf("%s rbusy%0d", tag, p), {31'h0, rbusy[p]}, {31'h0, exp_b});
        end
        @(posedge clk);
        m_edge();
        #1;
    endtask

    vec_t tbl_q[$];
    vec_t v;

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_mem[r]  = 32'h0;
            m_busy[r] = 1'b0;
        end
        rst = 1'b1; re = '0; ra_v = '0; we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0; iss_valid = 1'b0; iss_addr = '0;

        tbl_q.push_back(row (1, 0,0,32'h0, 0,0,32'h0, 0,0, 0, 20'h0, 128'h0, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 1,5,32'hDEADBEEF, 0,0, 5, 32'hDEADBEEF, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 0,0,32'h0, 0,0, 5, 32'hDEADBEEF, 0));
        tbl_q.push_back(row1(1, 1,5,32'h00001234, 0,0,32'h0, 1,5, 5, 32'h0, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 0,0,32'h0, 0,0, 5, 32'h0, 0));
        tbl_q.push_back(row1(0, 1,7,32'h11111111, 1,7,32'h22222222, 0,0, 7, 32'h22222222, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 0,0,32'h0, 0,0, 7, 32'h22222222, 0));
        tbl_q.push_back(row (0, 1,3,32'hA5A5A5A5, 1,9,32'h5A5A5A5A, 0,0, 15,
                             {5'd0, 5'd3, 5'd9, 5'd3},
                             {32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5}, 0));
        tbl_q.push_back(row (0, 0,0,32'h0, 0,0,32'h0, 0,0, 15,
                             {5'd0, 5'd3, 5'd9, 5'd3},
                             {32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5}, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 1,0,32'hFFFFFFFF, 1,0, 0, 32'h0, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 0,0,32'h0, 0,0, 0, 32'h0, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 0,0,32'h0, 1,12, 12, 32'h0, 0));
        tbl_q.push_back(row (0, 0,0,32'h0, 0,0,32'h0, 0,0, 1,
                             {5'd0, 5'd0, 5'd12, 5'd12}, 128'h0, 1));
        tbl_q.push_back(row1(0, 1,12,32'h0000CAFE, 0,0,32'h0, 0,0, 12, 32'h0000CAFE, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 0,0,32'h0, 0,0, 12, 32'h0000CAFE, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 1,4,32'h12345678, 1,4, 4, 32'h12345678, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 0,0,32'h0, 0,0, 4, 32'h12345678, 1));
        tbl_q.push_back(row1(0, 1,4,32'h00000009, 0,0,32'h0, 0,0, 4, 32'h00000009, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 0,0,32'h0, 0,0, 4, 32'h00000009, 0));
        tbl_q.push_back(row (0, 0,0,32'h0, 0,0,32'h0, 1,6, 0, 20'h0, 128'h0, 0));
        tbl_q.push_back(row1(1, 0,0,32'h0, 0,0,32'h0, 0,0, 6, 32'h0, 0));
        tbl_q.push_back(row1(0, 0,0,32'h0, 0,0,32'h0, 0,0, 6, 32'h0, 0));

        for (int i = 0; i < tbl_q.size(); i++) begin
            step(tbl_q[i], 1'b1, $sformatf("vec%0d", i));
        end

        // r20 stays busy across unrelated writes until its own producer retires.
        step(row(0, 0,0,32'h0, 0,0,32'h0, 1,20, 0, 20'h0, 128'h0, 0), 1'b1, "hold_iss");
        for (int k = 0; k < 3; k++) begin
            step(row(0, 1,21,32'h100 + 32'(k), 0,0,32'h0, 0,0, 3,
                     {5'd0, 5'd0, 5'd21, 5'd20},
                     {32'h0, 32'h0, 32'h100 + 32'(k), 32'h0}, 1),
                 1'b1, $sformatf("hold_busy%0d", k));
        end
        step(row(0, 0,0,32'h0, 1,20,32'hBEEF0001, 0,0, 3,
                 {5'd0, 5'd0, 5'd21, 5'd20},
                 {32'h0, 32'h0, 32'h102, 32'hBEEF0001}, 0), 1'b1, "clr_busy");
        step(row1(0, 0,0,32'h0, 0,0,32'h0, 0,0, 20, 32'hBEEF0001, 0), 1'b1, "after_clr");

        for (int n = 0; n < 600; n++) begin
            v = '0;
            v.rst = ($urandom_range(0, 63) == 0);
            v.we0 = 1'($urandom_range(0, 1));
            v.wa0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.wd0 = $urandom;
            v.we1 = 1'($urandom_range(0, 1));
            v.wa1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.wd1 = $urandom;
            v.iss = ($urandom_range(0, 2) == 0);
            v.ia  = 5'($urandom_range(0, 7));
            v.re  = 4'($urandom_range(0, 15));
            for (int p = 0; p < NRD; p++) begin
                v.ra[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            end
            step(v, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
